des_sbox_pipe: RTL and testbench
================================

Name: des_sbox_pipe

Overview:
Parametrised, pipelined bank of DES S-boxes for the 3DES round datapath.
- Takes a 6*NUM_BOXES-bit expanded/key-mixed word and substitutes each 6-bit group through its DES S-box (S1..S8).
- Returns a 4*NUM_BOXES-bit word through PIPE_DEPTH register stages.
- Uses a valid/ready handshake with synchronous flush.
- Sits between the key-XOR stage and the P-permutation in the round function.

Parameters:
NUM_BOXES, 8, number of S-boxes (1..8); group k (k=0 is MSB group) uses DES S-box S(k+1)
PIPE_DEPTH, 2, number of register stages (1..4); sets latency

Ports:
clk        input   1               rising-edge clock
rst_n      input   1               asynchronous active-low reset
flush      input   1               synchronous clear of all in-flight data
in_valid   input   1               input word valid
in_ready   output  1               block can accept input this cycle
in_data    input   6*NUM_BOXES     groups of 6 bits, S1 group at MSBs
out_valid  output  1               output word valid
out_ready  input   1               downstream accepts output
out_data   output  4*NUM_BOXES     substituted nibbles, S1 nibble at MSBs
busy       output  1               any pipeline stage holds valid data

Behaviour:
- Lookup per group g[5:0] (g[5] = DES bit 1): row = {g[5], g[0]}, col = g[4:1]; result = S-box(row, col).
  - Examples: S3(0)=10, S3(1)=13, S3(63)=12.
  - Lookup is combinational ahead of stage 0; all stages are registered.
- Pipeline: stages 0..PIPE_DEPTH-1, each holds data plus a valid bit. Stage PIPE_DEPTH-1 drives out_data/out_valid.
- Advance rule: stage i loads from stage i-1 (stage 0 from input) when stage i is empty, or stage i's contents move on in the same cycle.
  - Last stage moves on when out_valid && out_ready.
  - Bubbles collapse: stalled data never blocks an empty stage ahead.
- in_ready = stage 0 empty OR stage 0 advancing this cycle. Input is accepted only on in_valid && in_ready.
- Throughput: 1 word/clk with out_ready held high.
- Latency: PIPE_DEPTH cycles from accept to out_valid when there is no backpressure.
- out_data is held stable while out_valid && !out_ready. Data is never dropped or duplicated under any ready pattern.
- busy = OR of all stage valid bits.
- flush:
  - Clears all valid bits at the next edge; in_ready=1 on the following cycle.
  - A word presented with in_valid in the flush cycle is discarded, even if in_ready was 1.
  - flush has priority over every advance.
- Reset (rst_n low, asynchronous):
  - All valid bits = 0, out_valid = 0, busy = 0, out_data = 0, in_ready = 1 once rst_n deasserts.
  - Stage data registers reset to 0.
  - Reset mid-stream drops all in-flight words.
- Parameters out of range must fail elaboration.

Optional Feature:
- Macro DES_SBOX_PARITY_EN.
- When defined: adds output out_par [NUM_BOXES-1:0].
  - Bit k is the even parity (XOR) of nibble k of out_data.
  - Computed at the lookup and pipelined alongside the data, so it is aligned with out_data and out_valid.
  - Reset value 0; held under stall like the data.
- When not defined: port absent, no parity logic.

Test Plan:
1. Defaults, in_data=48'h0, single word, out_ready=1 -> out_valid exactly 2 cycles after accept, out_data=32'hEFA72C4D; with DES_SBOX_PARITY_EN, out_par=8'h9B.
2. in_data=48'hFFFFFFFFFFFF -> out_data=32'hD9CE3DCB. NUM_BOXES=1, in_data=6'd63 -> 4'd13 (S1 row 3, col 15).
3. 64 back-to-back words with in_data = {8{i[5:0]}}, out_ready=1 -> one output per clk, in order; nibble 2 (S3) matches, e.g. i=0 -> 10, i=1 -> 13, i=63 -> 12.
4. out_ready low for 5 cycles with continuous input, PIPE_DEPTH=2 -> pipeline fills (2 words), in_ready=0, out_data stable. On release, all words emerge in order with none lost.
5. Assert flush with 2 words in flight plus in_valid=1 -> next cycle busy=0, out_valid=0, in_ready=1; the flush-cycle word never appears.
6. Drop rst_n asynchronously between clock edges mid-stream -> out_valid, busy and out_data go to 0 immediately. After release, a new word of 48'h0 yields 32'hEFA72C4D with normal latency.

Source files
------------

// File: rtl/des_sbox_pipe.sv
// Pipelined bank of DES S-boxes (S1..S8) with valid/ready handshake and synchronous flush.
// Optional per-nibble parity output enabled by defining DES_SBOX_PARITY_EN.
module des_sbox_pipe #(
    parameter int NUM_BOXES  = 8,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6*NUM_BOXES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NUM_BOXES-1:0] out_data,
`ifdef DES_SBOX_PARITY_EN
    output logic [NUM_BOXES-1:0]   out_par,
`endif
    output logic                   busy
);

    if (NUM_BOXES < 1 || NUM_BOXES > 8) begin : g_bad_num_boxes
        $error("des_sbox_pipe: NUM_BOXES must be in 1..8");
    end
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_pipe_depth
        $error("des_sbox_pipe: PIPE_DEPTH must be in 1..4");
    end

    localparam int DW = 4 * NUM_BOXES;
`ifdef DES_SBOX_PARITY_EN
    localparam int SW = DW + NUM_BOXES;
`else
    localparam int SW = DW;
`endif

    // One entry per box: 64 nibbles, row-major (row*16 + col), entry 0 at the MSBs.
    localparam logic [255:0] SBOX_TAB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] grp);
        logic [255:0] tab;
        logic [5:0]   idx;
        tab = SBOX_TAB[box];
        idx = {grp[5], grp[0], grp[4:1]};
        return tab[255 - 4*int'(idx) -: 4];
    endfunction

    logic [DW-1:0] lut_nib;
    logic [SW-1:0] lut_word;

    always_comb begin
        lut_nib = '0;
        for (int k = 0; k < NUM_BOXES; k++) begin
            lut_nib[DW-1-4*k -: 4] = sbox_lookup(k, in_data[6*NUM_BOXES-1-6*k -: 6]);
        end
    end

`ifdef DES_SBOX_PARITY_EN
    logic [NUM_BOXES-1:0] lut_par;

    always_comb begin
        lut_par = '0;
        for (int k = 0; k < NUM_BOXES; k++) begin
            lut_par[k] = ^lut_nib[4*k +: 4];
        end
    end

    assign lut_word = {lut_nib, lut_par};
`else
    assign lut_word = lut_nib;
`endif

    logic [PIPE_DEPTH-1:0] stg_valid;
    logic [SW-1:0]         stg_data [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] ld;
    logic [PIPE_DEPTH:0]   src_valid;
    logic [SW-1:0]         src_data [PIPE_DEPTH+1];

    // A stage may load when empty or when its occupant moves on this cycle; this lets bubbles collapse.
    always_comb begin
        logic can_move;
        ld       = '0;
        can_move = !stg_valid[PIPE_DEPTH-1] || out_ready;
        ld[PIPE_DEPTH-1] = can_move;
        for (int i = PIPE_DEPTH-2; i >= 0; i--) begin
            can_move = !stg_valid[i] || can_move;
            ld[i]    = can_move;
        end
    end

    always_comb begin
        src_valid   = {stg_valid, in_valid};
        src_data[0] = lut_word;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            src_data[i+1] = stg_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                stg_data[i] <= '0;
            end
        end else if (flush) begin
            stg_valid <= '0;
        end else begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                if (ld[i]) begin
                    stg_valid[i] <= src_valid[i];
                    if (src_valid[i]) begin
                        stg_data[i] <= src_data[i];
                    end
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = stg_valid[PIPE_DEPTH-1];
    assign out_data  = stg_data[PIPE_DEPTH-1][SW-1 -: DW];
    assign busy      = |stg_valid;
`ifdef DES_SBOX_PARITY_EN
    assign out_par   = stg_data[PIPE_DEPTH-1][NUM_BOXES-1:0];
`endif

endmodule

// File: tb/tb_des_sbox_pipe.sv
// Self-checking bench for des_sbox_pipe: directed cases plus randomized traffic scored
// against a table-driven DES S-box model; a second small instance covers NUM_BOXES=1.
module tb_des_sbox_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
`ifdef DES_SBOX_PARITY_EN
    logic [7:0]  out_par;
`endif

    logic        s_flush;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [5:0]  s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [3:0]  s_out_data;
    logic        s_busy;
`ifdef DES_SBOX_PARITY_EN
    logic [0:0]  s_out_par;
`endif

    des_sbox_pipe #(.NUM_BOXES(8), .PIPE_DEPTH(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef DES_SBOX_PARITY_EN
        .out_par   (out_par),
`endif
        .busy      (busy)
    );

    des_sbox_pipe #(.NUM_BOXES(1), .PIPE_DEPTH(3)) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
`ifdef DES_SBOX_PARITY_EN
        .out_par   (s_out_par),
`endif
        .busy      (s_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int out_cnt = 0;
    logic [31:0] exp_q [$];

    // Textbook DES tables: entry box*4+row, 16 nibbles per row, column 0 at the MSBs.
    logic [63:0] sbox_rows [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    function automatic logic [3:0] ref_sbox(input int box, input int g);
        int row;
        int col;
        logic [63:0] r;
        row = (g / 32) * 2 + (g % 2);
        col = (g / 2) % 16;
        r   = sbox_rows[box*4 + row];
        return 4'(r >> (4 * (15 - col)));
    endfunction

    function automatic logic [31:0] ref_word(input logic [47:0] d, input int nb);
        logic [31:0] w;
        int sh;
        int g;
        w = '0;
        for (int k = 0; k < nb; k++) begin
            sh = nb - 1 - k;
            g  = int'((d >> (6 * sh)) & 48'h3F);
            w  = w | (32'(ref_sbox(k, g)) << (4 * sh));
        end
        return w;
    endfunction

    function automatic logic [7:0] ref_par(input logic [31:0] w);
        logic [7:0] p;
        for (int k = 0; k < 8; k++) p[k] = ^w[4*k +: 4];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes sampled mid-cycle, i.e. what the coming edge will do.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e));
`ifdef DES_SBOX_PARITY_EN
                    chk("out_par", 64'(out_par), 64'(ref_par(e)));
`endif
                    out_cnt++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_word(in_data, 8));
        end
    end

    task automatic single(input logic [47:0] d, input logic [31:0] expd, input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        step();
        in_valid  = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        step();
        chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(out_data), 64'(expd));
        step();
    endtask

    task automatic small_word(input logic [5:0] g);
        int lat;
        logic [3:0] e;
        s_in_valid = 1'b1;
        s_in_data  = g;
        step();
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 10) begin
            step();
            lat++;
        end
        e = 4'(ref_word(48'(g), 1));
        chk("small_lat", 64'(lat), 64'd3);
        chk("small_data", 64'(s_out_data), 64'(e));
`ifdef DES_SBOX_PARITY_EN
        chk("small_par", 64'(s_out_par), 64'(^e));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [47:0] w0;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // zero and all-ones vectors
        single(48'h0, 32'hEFA72C4D, "t1");
`ifdef DES_SBOX_PARITY_EN
        in_valid = 1'b1; in_data = 48'h0;
        step(); in_valid = 1'b0; step();
        chk("t1_par", 64'(out_par), 64'h9B);
        step();
`endif
        single(48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "t2");

        // single-box instance, three-deep pipe
        small_word(6'd63);
        chk("small_s1_63", 64'(s_out_data), 64'd13);
        for (int i = 0; i < 5; i++) small_word(6'($urandom_range(0, 63)));

        // back-to-back stream
        base = out_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = {8{i[5:0]}};
            chk("t3_in_ready", 64'(in_ready), 64'd1);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        chk("t3_count", 64'(out_cnt - base), 64'd64);

        // backpressure
        out_ready = 1'b0;
        w0 = 48'({$urandom(), $urandom()});
        in_valid = 1'b1;
        in_data  = w0;
        for (int i = 0; i < 5; i++) begin
            step();
            in_data = 48'({$urandom(), $urandom()});
        end
        chk("t4_in_ready", 64'(in_ready), 64'd0);
        chk("t4_out_valid", 64'(out_valid), 64'd1);
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_held_data", 64'(out_data), 64'(ref_word(w0, 8)));
        chk("t4_fill", 64'(exp_q.size()), 64'd2);
        base = out_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 48'({$urandom(), $urandom()});
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("t4_drained", 64'(exp_q.size()), 64'd0);
        chk("t4_count", 64'(out_cnt - base), 64'd8);

        // flush with two words in flight plus a presented word
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 48'({$urandom(), $urandom()});
            step();
        end
        flush = 1'b1;
        in_data = 48'({$urandom(), $urandom()});
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        base = out_cnt;
        out_ready = 1'b1;
        repeat (4) step();
        chk("t5_no_out", 64'(out_cnt - base), 64'd0);

        // flush on an empty pipe while in_ready is high
        out_ready = 1'b0;
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 48'h123456789ABC;
        chk("t5b_ready_in_flush", 64'(in_ready), 64'd1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5b_busy", 64'(busy), 64'd0);
        out_ready = 1'b1;
        repeat (3) step();
        chk("t5b_no_out", 64'(out_cnt - base), 64'd0);

        // asynchronous reset mid-stream
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 48'({$urandom(), $urandom()});
            step();
        end
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_out_data", 64'(out_data), 64'd0);
        step(); step();
        #2;
        rst_n = 1'b1;
        step();
        single(48'h0, 32'hEFA72C4D, "t6");

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 48'({$urandom(), $urandom()});
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        chk("t7_drained", 64'(exp_q.size()), 64'd0);
        chk("t7_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
